// File: rtl/fp_cvt_pkg.sv
// fp_cvt_pkg: rounding modes and IEEE-754 format helpers shared by the conversion path
package fp_cvt_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RUP = 3'd2,
        RM_RDN = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    function automatic int exp_width(input int fpwid);
        return fpwid == 16 ? 5 : fpwid == 64 ? 11 : fpwid == 128 ? 15 : 8;
    endfunction

    function automatic int man_width(input int fpwid);
        return fpwid - 1 - exp_width(fpwid);
    endfunction

    function automatic int exp_bias(input int fpwid);
        return (1 << (exp_width(fpwid) - 1)) - 1;
    endfunction

    // Magnitude field (exponent + mantissa, no sign) of infinity.
    function automatic logic [126:0] inf_mag(input int fpwid);
        return ((127'd1 << exp_width(fpwid)) - 127'd1) << man_width(fpwid);
    endfunction

    // Largest finite magnitude sits one code below infinity.
    function automatic logic [126:0] max_mag(input int fpwid);
        return inf_mag(fpwid) - 127'd1;
    endfunction

endpackage

// File: rtl/cntlz_n.sv
// cntlz_n: combinational leading-zero counter; all-zero input reports W
module cntlz_n #(
    parameter int W = 32
) (
    input  logic [W-1:0]       d,
    output logic [$clog2(W):0] lz
);
    localparam int LW = $clog2(W) + 1;

    // highest set bit wins because later iterations overwrite earlier ones
    always_comb begin
        lz = LW'(W);
        for (int k = 0; k < W; k++)
            if (d[k]) lz = LW'(W - 1 - k);
    end

endmodule

// File: rtl/i2f_pipe.sv
// i2f_pipe: three-stage integer to IEEE-754 converter with valid/ready flow control
module i2f_pipe
    import fp_cvt_pkg::*;
#(
    parameter int FPWID = 32,
    parameter int IWID  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [2:0]       rm,
    input  logic [IWID-1:0]  i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FPWID-1:0] o,
    output logic             inexact,
    output logic             overflow
);
    localparam int EXPW = exp_width(FPWID);
    localparam int MANW = man_width(FPWID);
    localparam int BIAS = exp_bias(FPWID);
    localparam int LW   = $clog2(IWID) + 1;
    localparam int FW   = IWID - 1;
    localparam int XW   = IWID + MANW + 1;
    localparam int EW   = 18;
    localparam logic [EW-1:0]  ELIM   = EW'((1 << EXPW) - 1);
    localparam logic [126:0]   INF_W  = inf_mag(FPWID);
    localparam logic [126:0]   MAXF_W = max_mag(FPWID);

    logic v1, v2, v3, adv;
    logic s1_sign, s1_zero;
    rm_e s1_rm;
    logic [IWID-1:0] s1_mag;
    logic s2_sign, s2_zero;
    rm_e s2_rm;
    logic [FW-1:0] s2_frac;
    logic [EW-1:0] s2_e;
    logic [LW-1:0] lz;

    logic [XW-1:0]    ext;
    logic [MANW-1:0]  mant;
    logic [MANW:0]    mant_r;
    logic             g, r, s, rnd, exceed, permit;
    logic [EW-1:0]    exp_pre, exp_b;
    logic [FPWID-1:0] res;
    logic             res_inx, res_ovf;

    assign adv       = ce & ~(v3 & ~out_ready);
    assign in_ready  = adv;
    assign out_valid = v3;

    cntlz_n #(.W(IWID)) u_lz (
        .d  (s1_mag),
        .lz (lz)
    );

    // valid bits move in lockstep; bubbles are kept, never squeezed out
    always_ff @(posedge clk)
        if (rst) {v1, v2, v3} <= '0;
        else if (adv) {v1, v2, v3} <= {in_valid, v1, v2};

    // S1: capture sign, magnitude (most negative value maps to 2^(IWID-1)) and zero
    always_ff @(posedge clk)
        if (adv && in_valid) begin
            s1_sign <= op & i[IWID-1];
            s1_mag  <= (op & i[IWID-1]) ? -i : i;
            s1_zero <= i == '0;
            s1_rm   <= rm > 3'd4 ? RM_RNE : rm_e'(rm);
        end

    // S2: normalise so the leading one is implicit; keep only the fraction below it
    always_ff @(posedge clk)
        if (adv && v1) begin
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_rm   <= s1_rm;
            s2_frac <= FW'(s1_mag << lz);
            s2_e    <= EW'(IWID - 1) - EW'(lz);
        end

    // S3 datapath: round, detect overflow on the exact magnitude, and pack
    always_comb begin
        ext     = {s2_frac, {(MANW + 2){1'b0}}};
        mant    = ext[XW-1 -: MANW];
        g       = mant[0];
        r       = ext[XW-1-MANW];
        s       = |ext[XW-2-MANW:0];
        rnd     = s2_rm == RM_RTZ ? 1'b0 :
                  s2_rm == RM_RUP ? (r | s) & ~s2_sign :
                  s2_rm == RM_RDN ? (r | s) & s2_sign :
                  s2_rm == RM_RMM ? r : r & (g | s);
        mant_r  = {1'b0, mant} + {{MANW{1'b0}}, rnd};
        exp_pre = s2_e + EW'(BIAS);
        exp_b   = exp_pre + EW'(mant_r[MANW]);
        exceed  = exp_pre + EW'(&mant & (r | s)) >= ELIM;
        permit  = s2_rm == RM_RNE || s2_rm == RM_RMM ||
                  (s2_rm == RM_RUP && !s2_sign) || (s2_rm == RM_RDN && s2_sign);
        res     = s2_zero ? '0 :
                  exceed  ? {s2_sign, (permit && exp_b >= ELIM) ? INF_W[FPWID-2:0] : MAXF_W[FPWID-2:0]} :
                            {s2_sign, exp_b[EXPW-1:0], mant_r[MANW-1:0]};
        res_inx = ~s2_zero & (r | s | exceed);
        res_ovf = ~s2_zero & exceed;
    end

    // S3 result register; holds across stalls and clock-enable gaps
    always_ff @(posedge clk)
        if (rst) begin
            o        <= '0;
            inexact  <= 1'b0;
            overflow <= 1'b0;
        end else if (adv && v2) begin
            o        <= res;
            inexact  <= res_inx;
            overflow <= res_ovf;
        end

endmodule

// File: tb/tb_i2f_pipe.sv
// tb_i2f_pipe: vector table, random scoreboard and flow-control sequences for i2f_pipe
module tb_i2f_pipe;
    logic clk = 1'b0;
    logic rst, ce, in_valid, op, out_ready;
    logic [2:0] rm;
    logic [127:0] iw;
    logic rdy_a, ov_a, inx_a, ovf_a, rdy_b, ov_b, inx_b, ovf_b;
    logic [31:0] o_a, o_b;
    int checks = 0, errors = 0, cyc = 0, consumed = 0, pushed = 0, last_lat = 0;

    typedef struct {
        logic [31:0] o_a; logic x_a; logic f_a;
        logic [31:0] o_b; logic x_b; logic f_b;
        bit c_a; bit c_b; int cyc;
    } exp_t;

    typedef struct {
        bit wide; bit op; logic [2:0] rm; logic [127:0] i;
        logic [31:0] o; bit x; bit f;
    } vec_t;

    exp_t q[$];
    exp_t cur;
    vec_t tab[15];
    bit hold = 1'b0;
    logic [34:0] held_a, held_b;

    always #5 clk = ~clk;

    i2f_pipe #(.FPWID(32), .IWID(32)) u_a (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_ready(rdy_a),
        .op(op), .rm(rm), .i(iw[31:0]), .out_valid(ov_a), .out_ready(out_ready),
        .o(o_a), .inexact(inx_a), .overflow(ovf_a)
    );

    i2f_pipe #(.FPWID(32), .IWID(128)) u_b (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_ready(rdy_b),
        .op(op), .rm(rm), .i(iw), .out_valid(ov_b), .out_ready(out_ready),
        .o(o_b), .inexact(inx_b), .overflow(ovf_b)
    );

    // Reference: exact integer rounding by remainder-vs-half comparison, binary32 only.
    // Returns {overflow, inexact, result}.
    function automatic logic [33:0] model(input logic [127:0] x, input int w, input bit sg, input logic [2:0] m);
        logic [128:0] mag, q2, rem, half, maxf;
        bit sn, inx, up, ovf;
        int e, sh;
        logic [31:0] res;
        mag = '0;
        for (int k = 0; k < w; k++) mag[k] = x[k];
        sn = sg && x[w-1];
        if (sn) mag = (129'd1 << w) - mag;
        if (mag == 0) return 34'd0;
        e = 0;
        for (int k = 0; k < 129; k++) if (mag[k]) e = k;
        inx = 1'b0;
        up = 1'b0;
        if (e <= 23) q2 = mag << (23 - e);
        else begin
            sh   = e - 23;
            q2   = mag >> sh;
            rem  = mag - (q2 << sh);
            half = 129'd1 << (sh - 1);
            inx  = rem != 0;
            if (m == 3'd1) up = 1'b0;
            else if (m == 3'd2) up = inx && !sn;
            else if (m == 3'd3) up = inx && sn;
            else if (m == 3'd4) up = rem >= half;
            else up = rem > half || (rem == half && q2[0]);
        end
        q2 = q2 + 129'(up);
        if (q2[24]) begin q2 = q2 >> 1; e++; end
        maxf = 129'hFFFFFF << 104;
        ovf = mag > maxf;
        if (e + 127 >= 255) res = {sn, 8'hFF, 23'd0};
        else res = {sn, 8'(e + 127), q2[22:0]};
        return {ovf, inx | ovf, res};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: settle, check holds/handshake, scoreboard, then advance to next low phase.
    task automatic step();
        exp_t e;
        #1;
        if (hold) begin
            chk("hold_a", {ov_a, inx_a, ovf_a, o_a}, held_a);
            chk("hold_b", {ov_b, inx_b, ovf_b, o_b}, held_b);
        end
        if (!rst && ov_a && !out_ready) chk("stall_ready", rdy_a, 0);
        if (!ce) chk("ce_ready", rdy_a, 0);
        if (!rst && ce && ov_a && out_ready) begin
            if (q.size() == 0) chk("spurious_out", ov_a, 0);
            else begin
                e = q.pop_front();
                if (e.c_a) chk("res_a", {inx_a, ovf_a, o_a}, {e.x_a, e.f_a, e.o_a});
                if (e.c_b) chk("res_b", {inx_b, ovf_b, o_b}, {e.x_b, e.f_b, e.o_b});
                last_lat = cyc - e.cyc;
                consumed++;
            end
        end
        if (!rst && in_valid && rdy_a) begin
            cur.cyc = cyc;
            q.push_back(cur);
            pushed++;
        end
        hold = !rst && (!ce || (ov_a && !out_ready));
        held_a = {ov_a, inx_a, ovf_a, o_a};
        held_b = {ov_b, inx_b, ovf_b, o_b};
        if (rst) q.delete();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_rand(input bit v);
        logic [127:0] x;
        logic [33:0] ma, mb;
        x = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 6))
            0: x = '0;
            1: x = '1;
            2: x = 128'd1 << $urandom_range(0, 127);
            3: x = x >> $urandom_range(0, 127);
            4: x[31:0] = 32'h8000_0000;
            default: ;
        endcase
        in_valid = v;
        op = 1'($urandom);
        rm = 3'($urandom_range(0, 7));
        iw = x;
        ma = model(x, 32, op, rm);
        mb = model(x, 128, op, rm);
        cur = '{ma[31:0], ma[32], ma[33], mb[31:0], mb[32], mb[33], 1'b1, 1'b1, 0};
    endtask

    task automatic drain(input string nm);
        in_valid = 1'b0;
        ce = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && q.size() > 0; n++) step();
        chk(nm, q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tab[0]  = '{1'b0, 1'b1, 3'd0, 128'h1,          32'h3F800000, 1'b0, 1'b0};
        tab[1]  = '{1'b0, 1'b1, 3'd0, 128'hFFFFFFFF,   32'hBF800000, 1'b0, 1'b0};
        tab[2]  = '{1'b0, 1'b1, 3'd0, 128'h80000000,   32'hCF000000, 1'b0, 1'b0};
        tab[3]  = '{1'b0, 1'b1, 3'd0, 128'h0,          32'h00000000, 1'b0, 1'b0};
        tab[4]  = '{1'b0, 1'b0, 3'd0, 128'hFFFFFFFF,   32'h4F800000, 1'b1, 1'b0};
        tab[5]  = '{1'b0, 1'b0, 3'd1, 128'hFFFFFFFF,   32'h4F7FFFFF, 1'b1, 1'b0};
        tab[6]  = '{1'b0, 1'b0, 3'd0, 128'h01000001,   32'h4B800000, 1'b1, 1'b0};
        tab[7]  = '{1'b0, 1'b0, 3'd2, 128'h01000001,   32'h4B800001, 1'b1, 1'b0};
        tab[8]  = '{1'b0, 1'b0, 3'd4, 128'h01000001,   32'h4B800001, 1'b1, 1'b0};
        tab[9]  = '{1'b0, 1'b0, 3'd7, 128'h01000001,   32'h4B800000, 1'b1, 1'b0};
        tab[10] = '{1'b0, 1'b1, 3'd3, 128'hFEFFFFFF,   32'hCB800001, 1'b1, 1'b0};
        tab[11] = '{1'b1, 1'b0, 3'd0, '1,              32'h7F800000, 1'b1, 1'b1};
        tab[12] = '{1'b1, 1'b0, 3'd1, '1,              32'h7F7FFFFF, 1'b1, 1'b1};
        tab[13] = '{1'b1, 1'b1, 3'd3, 128'h1 << 127,   32'hFF000000, 1'b0, 1'b0};
        tab[14] = '{1'b1, 1'b1, 3'd0, '1,              32'hBF800000, 1'b0, 1'b0};

        rst = 1'b1; ce = 1'b1; in_valid = 1'b0; op = 1'b0; rm = 3'd0; iw = '0; out_ready = 1'b1;
        cur = '{default: 0};
        @(negedge clk);
        step();
        step();
        chk("reset_valid", ov_a, 0);
        chk("reset_o", {o_a, o_b}, 0);
        chk("reset_flags", {inx_a, ovf_a, inx_b, ovf_b}, 0);
        rst = 1'b0;
        #1 chk("ready_after_reset", rdy_a, 1);

        foreach (tab[k]) begin
            in_valid = 1'b1; op = tab[k].op; rm = tab[k].rm; iw = tab[k].i;
            cur = '{default: 0};
            if (tab[k].wide) begin
                cur.o_b = tab[k].o; cur.x_b = tab[k].x; cur.f_b = tab[k].f; cur.c_b = 1'b1;
            end else begin
                cur.o_a = tab[k].o; cur.x_a = tab[k].x; cur.f_a = tab[k].f; cur.c_a = 1'b1;
            end
            step();
            in_valid = 1'b0;
            for (int n = 0; n < 8 && q.size() > 0; n++) step();
            chk("tab_drain", q.size(), 0);
            chk("tab_latency", last_lat, 3);
        end

        for (int n = 0; n < 400; n++) begin
            set_rand($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 2) != 0;
            ce = $urandom_range(0, 9) != 0;
            step();
        end
        drain("rand_drain");

        pushed = 0;
        consumed = 0;
        for (int n = 0; n < 300 && pushed < 8; n++) begin
            set_rand($urandom_range(0, 2) != 0);
            out_ready = 1'($urandom);
            step();
        end
        drain("bp_drain");
        chk("bp_count", consumed, 8);

        for (int n = 0; n < 2; n++) begin set_rand(1'b1); step(); end
        ce = 1'b0;
        for (int n = 0; n < 3; n++) begin set_rand(1'b1); step(); end
        drain("ce_drain");

        for (int n = 0; n < 3; n++) begin set_rand(1'b1); step(); end
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        #1 chk("rst_flush_valid", {ov_a, ov_b}, 0);
        chk("rst_flush_o", {o_a, o_b}, 0);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) step();
        set_rand(1'b1);
        step();
        drain("post_rst_drain");
        chk("post_rst_latency", last_lat, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
